// File: rtl/game_screen_ctrl_pkg.sv
// rtl/game_screen_ctrl_pkg.sv - shared state encodings and colour constants for the game screens
package game_screen_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_TITLE  = 2'd0,
        ST_PLAY   = 2'd1,
        ST_DYING  = 2'd2,
        ST_ENDING = 2'd3
    } screen_state_t;

    // Background shown around the ending overlay
    localparam logic [11:0] ENDING_BG_RGB = 12'h7CC;

    // Death flash: pass the colour through or invert every channel
    function automatic logic [11:0] flash_rgb(input logic [11:0] rgb, input logic invert);
        return invert ? ~rgb : rgb;
    endfunction

endpackage

// File: rtl/frame_counter.sv
// rtl/frame_counter.sv - free-running frame counter that wraps at a parameterised modulus
module frame_counter #(
    parameter int WRAP  = 60,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(WRAP - 1);

    // Advance once per tick, returning to zero after LAST so the count never reaches WRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/game_screen_ctrl.sv
// rtl/game_screen_ctrl.sv - screen sequencing FSM and registered pixel mux for the game
import game_screen_ctrl_pkg::*;

module game_screen_ctrl #(
    parameter int BLINK_FRAMES = 60,
    parameter int DEATH_FRAMES = 30,
    parameter int LOCK_FRAMES  = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        btn,
    input  logic        collision,
    input  logic [11:0] title_rgb,
    input  logic [11:0] game_rgb,
    input  logic [11:0] ending_rgb,
    input  logic        is_ending_region,
    output logic [1:0]  state,
    output logic        game_run,
    output logic        game_clear,
    output logic [5:0]  blink_count,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    // DYING ends on the tick that completes its last frame
    localparam logic [5:0] DEATH_LAST = 6'(DEATH_FRAMES - 1);
    localparam logic [5:0] LOCK_MIN   = 6'(LOCK_FRAMES);

    screen_state_t state_q, state_d;
    logic [5:0]    frame_cnt;
    logic          btn_prev;
    logic          btn_press;
    logic          state_change;
    logic          clear_d;
    logic [11:0]   pix_d, pix_q;

    assign btn_press    = btn & ~btn_prev;
    assign state_change = (state_d != state_q);

    // Remember the previous button level; reset high so a held button is not a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev <= 1'b1;
        end else begin
            btn_prev <= btn;
        end
    end

    // Next-state decode; collision outranks a simultaneous press in PLAY
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        case (state_q)
            ST_TITLE: begin
                if (btn_press) begin
                    state_d = ST_PLAY;
                    clear_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (collision) begin
                    state_d = ST_DYING;
                end
            end
            ST_DYING: begin
                if (frame_tick && (frame_cnt == DEATH_LAST)) begin
                    state_d = ST_ENDING;
                end
            end
            ST_ENDING: begin
                // frame_cnt serves as the lock counter here; early presses are dropped
                if (btn_press && (frame_cnt >= LOCK_MIN)) begin
                    state_d = ST_TITLE;
                    clear_d = 1'b1;
                end
            end
            default: state_d = ST_TITLE;
        endcase
    end

    // State register with its registered companion outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_TITLE;
            game_run   <= 1'b0;
            game_clear <= 1'b0;
        end else begin
            state_q    <= state_d;
            game_run   <= (state_d == ST_PLAY);
            game_clear <= clear_d;
        end
    end

    // Frames spent in the current state; a state change wins over a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (state_change) begin
            frame_cnt <= '0;
        end else if (frame_tick && (frame_cnt != 6'd63)) begin
            frame_cnt <= frame_cnt + 6'd1;
        end
    end

    frame_counter #(
        .WRAP  (BLINK_FRAMES),
        .WIDTH (6)
    ) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (frame_tick),
        .count (blink_count)
    );

    // Pixel source chosen by the current state register
    always_comb begin
        pix_d = title_rgb;
        case (state_q)
            ST_TITLE:  pix_d = title_rgb;
            ST_PLAY:   pix_d = game_rgb;
            ST_DYING:  pix_d = flash_rgb(game_rgb, frame_cnt[2]);
            ST_ENDING: pix_d = is_ending_region ? ending_rgb : ENDING_BG_RGB;
            default:   pix_d = title_rgb;
        endcase
    end

    // One-cycle pixel pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign state = state_q;
    assign vga_r = pix_q[11:8];
    assign vga_g = pix_q[7:4];
    assign vga_b = pix_q[3:0];

endmodule
